// File: rtl/motor_seq_pkg.sv
// motor_seq_pkg: shared types for the per-wheel motor command sequencer.
// Holds the sequencer state encoding, the velocity word width and type,
// and the command clamp helper.
package motor_seq_pkg;

  localparam int VEL_W = 32;

  typedef logic signed [VEL_W-1:0] vel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STOP   = 2'd2,
    HALTED = 2'd3
  } seq_state_t;

  // Saturate a signed velocity to +/-lim (lim is positive).
  function automatic vel_t clamp_vel(input vel_t v, input vel_t lim);
    if (v > lim)  return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/slew_limiter.sv
// slew_limiter: combinational rate limiter.
// Returns tgt when it is within +/-step of cur; otherwise returns cur moved
// one step toward tgt. The difference is taken in VEL_W+1 bits so that
// opposite full-scale values cannot wrap. Also suitable for gain ramping.
module slew_limiter
  import motor_seq_pkg::*;
(
  input  logic signed [VEL_W-1:0] cur,
  input  logic signed [VEL_W-1:0] tgt,
  input  logic signed [VEL_W-1:0] step,
  output logic signed [VEL_W-1:0] nxt
);

  logic signed [VEL_W:0] diff;
  logic signed [VEL_W:0] step_x;

  // Pick the target, or one step toward it.
  // NOTE: every output of an always_comb gets a default on each path, or a latch is inferred.
  always_comb begin
    diff   = {tgt[VEL_W-1], tgt} - {cur[VEL_W-1], cur};
    step_x = {step[VEL_W-1], step};
    nxt    = tgt;
    if (diff > step_x || diff < -step_x) begin
      if (!diff[VEL_W]) nxt = cur + step;
      else              nxt = cur - step;
    end
  end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer: latches software velocity commands, slew-limits them
// on a fixed control tick, and enforces a command watchdog and an emergency
// stop before driving motor_ctrl.target_rot_v. One instance per wheel.
// Build option: MOTOR_CMD_SEQUENCER_HARD_STOP_EN makes estop zero the output
// on the next cycle and go straight to HALTED; watchdog stops still ramp.
module motor_cmd_sequencer
  import motor_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 200_000_000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned STEP      = 16,
  parameter vel_t        VMAX      = 32'sd4096,
  parameter int unsigned WDT_TICKS = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [VEL_W-1:0] cmd_v,
  input  logic                    cmd_valid,
  input  logic                    estop,
  input  logic                    clear,
  output logic signed [VEL_W-1:0] out_v,
  output logic                    tick,
  output logic [1:0]              state,
  output logic                    wdt_expired
);

  localparam int unsigned TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WDT_W    = $clog2(WDT_TICKS + 1);
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [WDT_W-1:0] WDT_MAX  = WDT_W'(WDT_TICKS - 1);
  localparam vel_t STEP_V = vel_t'(STEP);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] tick_cnt;
  logic [WDT_W-1:0] wdt_cnt;
  vel_t             target, out_q, out_d, slew_tgt, slew_nxt;
  logic             wdt_hit, cmd_accept;

  assign tick = (tick_cnt == TICK_MAX);

  // The watchdog fires on the tick that would bring the count to WDT_TICKS.
  assign wdt_hit = (state_q == RUN) && tick && (wdt_cnt == WDT_MAX);

  // estop and expiry both outrank a coincident command.
  assign cmd_accept = cmd_valid && !estop && !wdt_hit &&
                      (state_q == IDLE || state_q == RUN);

  // Once a stop is decided, the ramp heads for zero from that same tick.
  assign slew_tgt = (state_q == RUN && !estop && !wdt_hit) ? target : '0;

  slew_limiter u_slew (
    .cur  (out_q),
    .tgt  (slew_tgt),
    .step (STEP_V),
    .nxt  (slew_nxt)
  );

  // Free-running control-tick divider, active in every state.
  // NOTE: reset is synchronous here; it is just the highest-priority branch on the clock edge.
  always_ff @(posedge clk) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and next output velocity; estop is tested before expiry.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        out_d = '0;
        if (estop)          state_d = HALTED;
        else if (cmd_valid) state_d = RUN;
      end
      RUN: begin
        if (tick) out_d = slew_nxt;
        if (estop) begin
`ifdef MOTOR_CMD_SEQUENCER_HARD_STOP_EN
          state_d = HALTED;
          out_d   = '0;
`else
          state_d = STOP;
`endif
        end else if (wdt_hit) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (out_q == '0) state_d = HALTED;
        else if (tick)   out_d   = slew_nxt;
      end
      HALTED: begin
        out_d = '0;
        if (clear && !estop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output velocity, latched target, watchdog count and sticky expiry flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      target      <= '0;
      wdt_cnt     <= '0;
      wdt_expired <= 1'b0;
    end else begin
      out_q <= out_d;
      if (cmd_accept) target <= clamp_vel(cmd_v, VMAX);
      if (state_d != RUN || cmd_accept) wdt_cnt <= '0;
      else if (tick)                    wdt_cnt <= wdt_cnt + 1'b1;
      if (wdt_hit && !estop)                       wdt_expired <= 1'b1;
      else if (state_q == HALTED && clear && !estop) wdt_expired <= 1'b0;
    end
  end

  assign out_v = out_q;
  assign state = state_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// tb_motor_cmd_sequencer: directed scenarios followed by randomized stimulus,
// every cycle compared against a behavioural model of the sequencer.
// Configuration: tick every 10 cycles, STEP=16, VMAX=4096, WDT_TICKS=5.
module tb_motor_cmd_sequencer;

  localparam int TICK_DIV = 10;
  localparam int STEP     = 16;
  localparam int VMAX     = 4096;
  localparam int WDT      = 5;

  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_STOP   = 2;
  localparam int S_HALTED = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [31:0] cmd_v = '0;
  logic               cmd_valid = 1'b0;
  logic               estop = 1'b0;
  logic               clear = 1'b0;
  logic signed [31:0] out_v;
  logic               tick;
  logic [1:0]         state;
  logic               wdt_expired;

  int total = 0;
  int bad   = 0;

  // Model of the sequencer's observable behaviour.
  int     m_state;
  longint m_out;
  longint m_tgt;
  int     m_ticks_idle;   // ticks since the last accepted command in RUN
  bit     m_exp;
  int     m_phase;        // cycles since reset, modulo the tick period

  motor_cmd_sequencer #(
    .CLK_FREQ  (1000),
    .TICK_HZ   (100),
    .STEP      (16),
    .VMAX      (32'sd4096),
    .WDT_TICKS (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_v       (cmd_v),
    .cmd_valid   (cmd_valid),
    .estop       (estop),
    .clear       (clear),
    .out_v       (out_v),
    .tick        (tick),
    .state       (state),
    .wdt_expired (wdt_expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint clampv(input logic signed [31:0] v);
    longint x = v;
    if (x > VMAX)  return VMAX;
    if (x < -VMAX) return -VMAX;
    return x;
  endfunction

  function automatic longint approach(input longint cur, input longint goal);
    longint d = goal - cur;
    if (d <= STEP && d >= -STEP) return goal;
    return (d > 0) ? cur + STEP : cur - STEP;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_out = 0; m_tgt = 0;
    m_ticks_idle = 0; m_exp = 1'b0; m_phase = 0;
  endtask

  // Advance the model by one clock given this cycle's inputs.
  task automatic model_next(input logic signed [31:0] c, input bit v,
                            input bit es, input bit clr);
    bit t = (m_phase == TICK_DIV - 1);
    case (m_state)
      S_IDLE: begin
        m_out = 0;
        if (es) m_state = S_HALTED;
        else if (v) begin
          m_state = S_RUN; m_tgt = clampv(c); m_ticks_idle = 0;
        end
      end
      S_RUN: begin
        if (es) begin
`ifdef MOTOR_CMD_SEQUENCER_HARD_STOP_EN
          m_out = 0; m_state = S_HALTED;
`else
          m_state = S_STOP;
          if (t) m_out = approach(m_out, 0);
`endif
        end else if (t && m_ticks_idle + 1 >= WDT) begin
          m_state = S_STOP; m_exp = 1'b1;
          m_out = approach(m_out, 0);
        end else begin
          if (t) m_out = approach(m_out, m_tgt);
          if (v) begin
            m_tgt = clampv(c); m_ticks_idle = 0;
          end else if (t) begin
            m_ticks_idle++;
          end
        end
      end
      S_STOP: begin
        if (m_out == 0) m_state = S_HALTED;
        else if (t)     m_out = approach(m_out, 0);
      end
      default: begin
        m_out = 0;
        if (clr && !es) begin
          m_state = S_IDLE; m_exp = 1'b0;
        end
      end
    endcase
    m_phase = (m_phase + 1) % TICK_DIV;
  endtask

  task automatic compare_all();
    check("out_v", out_v, m_out);
    check("state", state, m_state);
    check("tick", tick, m_phase == TICK_DIV - 1);
    check("wdt_expired", wdt_expired, m_exp);
  endtask

  task automatic step(input logic signed [31:0] c, input bit v,
                      input bit es, input bit clr);
    cmd_v = c; cmd_valid = v; estop = es; clear = clr; reset = 1'b0;
    model_next(c, v, es, clr);
    @(posedge clk); #1;
    compare_all();
    cmd_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; clear = 1'b0;
    model_reset();
    @(posedge clk); #1;
    compare_all();
    reset = 1'b0;
  endtask

  // Hold a command, re-strobing it every 30 cycles to keep the watchdog fed.
  task automatic run_kick(input int n, input logic signed [31:0] c);
    for (int i = 0; i < n; i++) step(c, (i % 30) == 0, 1'b0, 1'b0);
  endtask

  // Idle until the next step starts at the beginning of a tick period.
  task automatic align();
    for (int i = 0; i < TICK_DIV && m_phase != 0; i++) step('0, 1'b0, estop, 1'b0);
  endtask

  task automatic wait_halted(input bit es);
    for (int i = 0; i < 400 && m_state != S_HALTED; i++) step('0, 1'b0, es, 1'b0);
    check("reach_halted", state, S_HALTED);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit                 es_lvl;
    bit                 v;
    logic signed [31:0] c;

    // Reset state.
    do_reset();
    check("rst_out", out_v, 0);
    check("rst_state", state, S_IDLE);
    check("rst_tick", tick, 0);
    check("rst_wdt", wdt_expired, 0);

    // Small command: 16,32,...,96 then 100 on the 7th tick.
    step(32'sd100, 1'b1, 1'b0, 1'b0);
    check("cmd_run", state, S_RUN);
    run_kick(69, 32'sd100);
    check("slew_100", out_v, 100);

    // Oversized command saturates, then a negative command settles exactly.
    run_kick(2700, 32'sd10000);
    check("clamp_vmax", out_v, 4096);
    run_kick(2700, -32'sd50);
    check("settle_neg50", out_v, -50);

    // Watchdog expiry on the 5th tick after the last command at 64.
    run_kick(100, 32'sd64);
    align();
    step(32'sd64, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 48; i++) step(32'sd64, 1'b0, 1'b0, 1'b0);
    check("wdt_pre_state", state, S_RUN);
    step(32'sd64, 1'b0, 1'b0, 1'b0);
    check("wdt_stop_state", state, S_STOP);
    check("wdt_flag", wdt_expired, 1);
    check("wdt_first_ramp", out_v, 48);
    wait_halted(1'b0);
    check("wdt_halt_out", out_v, 0);
    step('0, 1'b0, 1'b0, 1'b1);
    check("wdt_clear_state", state, S_IDLE);
    check("wdt_clear_flag", wdt_expired, 0);

    // estop while running at 200.
    step(32'sd200, 1'b1, 1'b0, 1'b0);
    run_kick(150, 32'sd200);
    check("run_200", out_v, 200);
    if (m_phase == TICK_DIV - 1) step(32'sd200, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1, 1'b0);
`ifdef MOTOR_CMD_SEQUENCER_HARD_STOP_EN
    check("estop_state", state, S_HALTED);
    check("estop_out", out_v, 0);
`else
    check("estop_state", state, S_STOP);
    check("estop_out", out_v, 200);
`endif
    wait_halted(1'b1);
    check("estop_no_wdt", wdt_expired, 0);
    step('0, 1'b0, 1'b1, 1'b1);
    check("clear_blocked", state, S_HALTED);
    step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b1);
    check("clear_ok", state, S_IDLE);

    // Command coincident with the expiring tick is discarded.
    align();
    step(32'sd64, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 48; i++) step(32'sd64, 1'b0, 1'b0, 1'b0);
    step(32'sd1000, 1'b1, 1'b0, 1'b0);
    check("coinc_state", state, S_STOP);
    check("coinc_flag", wdt_expired, 1);
    check("coinc_out", out_v, 48);
    wait_halted(1'b0);
    step('0, 1'b0, 1'b0, 1'b1);

    // Reset mid-ramp at 48.
    align();
    step(32'sd100, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 29; i++) step(32'sd100, 1'b0, 1'b0, 1'b0);
    check("ramp_48", out_v, 48);
    do_reset();
    check("mid_rst_out", out_v, 0);
    check("mid_rst_state", state, S_IDLE);
    check("mid_rst_flag", wdt_expired, 0);
    for (int i = 0; i < TICK_DIV - 1; i++) step('0, 1'b0, 1'b0, 1'b0);
    check("tick_after_rst", tick, 1);

    // Randomized traffic against the model.
    es_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 199) == 0) es_lvl = !es_lvl;
        v = (i < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 3) == 0) c = $urandom;
        else                           c = int'($urandom_range(0, 12000)) - 6000;
        step(c, v, es_lvl, (m_state == S_HALTED) && ($urandom_range(0, 3) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
